// File: rtl/and_serial_scheduler_pkg.sv
// ============================================================================
//  Module      : and_serial_scheduler_pkg
//  Description : Shared state encodings, requester IDs and counter sizing
//                for the bit-serial AND scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package and_serial_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    // Bit counter must hold WIDTH-1 and is never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/and_bit_slice.sv
// ============================================================================
//  Module      : and_bit_slice
//  Description : Single-bit AND cell; the one shared datapath resource.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module and_bit_slice (
    input  logic a,
    input  logic b,
    output logic out
);

    assign out = a & b;

endmodule

`default_nettype wire

// File: rtl/and_serial_scheduler.sv
// ============================================================================
//  Module      : and_serial_scheduler
//  Description : Round-robin arbitration of two requesters onto one shared
//                AND bit-slice, processed LSB-first one bit per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module and_serial_scheduler
    import and_serial_scheduler_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e             state_q,    state_d;
    logic               ptr_q,      ptr_d;
    logic               id_q,       id_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [WIDTH-1:0]   a_sh_q,     a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,     b_sh_d;
    logic [WIDTH-1:0]   res_q,      res_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_id_q,   rsp_id_d;

    logic               w_grant0;
    logic               w_grant1;
    logic               w_slice_out;

    and_bit_slice u_slice (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .out (w_slice_out)
    );

    // Grants depend only on valids, state and the pointer - never on ready.
    assign w_grant0 = (state_q == ST_IDLE) && req0_valid
                      && (!req1_valid || (ptr_q == ID_REQ0));
    assign w_grant1 = (state_q == ST_IDLE) && req1_valid
                      && (!req0_valid || (ptr_q == ID_REQ1));

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp_valid  = (state_q == ST_DONE);
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        res_d      = res_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;

        case (state_q)
            ST_IDLE: begin
                if (w_grant0 || w_grant1) begin
                    a_sh_d  = w_grant1 ? req1_a : req0_a;
                    b_sh_d  = w_grant1 ? req1_b : req0_b;
                    id_d    = w_grant1 ? ID_REQ1 : ID_REQ0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // New bit enters at the MSB so LSB-first results land in place.
                res_d  = (res_q >> 1) | (WIDTH'(w_slice_out) << (WIDTH - 1));
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    rsp_data_d = res_d;
                    rsp_id_d   = id_q;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    ptr_d   = ~rsp_id_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= ID_REQ0;
            id_q       <= ID_REQ0;
            cnt_q      <= '0;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            res_q      <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= ID_REQ0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            res_q      <= res_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

endmodule

`default_nettype wire
